// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and checker FSM state definitions
//
// Purpose: opcode encodings used by the ALU, its reference model and the
// result checker, plus the checker FSM state encoding.
// Ports: none (package).

package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } stateT;

endpackage

// File: rtl/alu_result_checker_if.sv
// rtl/alu_result_checker_if.sv - stimulus snoop and result bus of the ALU checker
//
// Purpose: groups the run control, snooped ALU operand bus, ALU output and
// checker status/debug outputs.
// Modports:
//   master - stimulus side: drives iSTART/iSTOP/iVALID/iOPCODE/iDATAIN1/
//            iDATAIN2/iDUTOUT, reads all o* status.
//   slave  - checker side: the reverse.

interface alu_result_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);

  logic              iSTART;
  logic              iSTOP;
  logic              iVALID;
  logic [1:0]        iOPCODE;
  logic [DATA_W-1:0] iDATAIN1;
  logic [DATA_W-1:0] iDATAIN2;
  logic [DATA_W-1:0] iDUTOUT;

  logic              oBUSY;
  logic              oDONE;
  logic [CNT_W-1:0]  oPASS_CNT;
  logic [CNT_W-1:0]  oFAIL_CNT;
  logic              oERR;
  logic [CNT_W-1:0]  oFAIL_IDX;
  logic [1:0]        oFAIL_OPCODE;
  logic [DATA_W-1:0] oFAIL_EXP;
  logic [DATA_W-1:0] oFAIL_GOT;

  modport master (
    output iSTART, iSTOP, iVALID, iOPCODE, iDATAIN1, iDATAIN2, iDUTOUT,
    input  oBUSY, oDONE, oPASS_CNT, oFAIL_CNT, oERR,
           oFAIL_IDX, oFAIL_OPCODE, oFAIL_EXP, oFAIL_GOT
  );

  modport slave (
    input  iSTART, iSTOP, iVALID, iOPCODE, iDATAIN1, iDATAIN2, iDUTOUT,
    output oBUSY, oDONE, oPASS_CNT, oFAIL_CNT, oERR,
           oFAIL_IDX, oFAIL_OPCODE, oFAIL_EXP, oFAIL_GOT
  );

endinterface

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational ALU reference model
//
// Purpose: computes the expected ALU result, truncated to DATA_W bits.
// Ports:
//   opcode  in  2       ALU opcode (OP_ADD/OP_SUB/OP_AND/OP_OR)
//   a       in  DATA_W  operand A
//   b       in  DATA_W  operand B
//   result  out DATA_W  expected result

module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - self-checking response side of the ALU
//
// Purpose: snoops the ALU operand/opcode bus, computes the expected result,
// delays it by LATENCY clocks, compares with the ALU output, counts
// passes/fails and captures the first mismatch of a run.
// Ports:
//   iCLK   in  1  clock, rising edge
//   iRSTN  in  1  synchronous active-low reset
//   bus    alu_result_checker_if.slave  run control, snooped bus, status

module alu_result_checker
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 iCLK,
  input  logic                 iRSTN,
  alu_result_checker_if.slave  bus
);

  // Drain counter is loaded with LATENCY-1 so DRAIN lasts exactly LATENCY cycles.
  localparam int DRAIN_W = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(LATENCY - 1);

  stateT               state;
  stateT               stateNext;
  logic [DRAIN_W-1:0]  drainCnt;

  logic                busyQ;
  logic                doneQ;
  logic [CNT_W-1:0]    passCnt;
  logic [CNT_W-1:0]    failCnt;
  logic                errQ;
  logic [CNT_W-1:0]    failIdx;
  logic [1:0]          failOp;
  logic [DATA_W-1:0]   failExp;
  logic [DATA_W-1:0]   failGot;
  logic [CNT_W-1:0]    sampleIdx;

  logic                pipeValid [LATENCY];
  logic [DATA_W-1:0]   pipeExp   [LATENCY];
  logic [1:0]          pipeOp    [LATENCY];
  logic [CNT_W-1:0]    pipeIdx   [LATENCY];

  logic [DATA_W-1:0]   expNow;
  logic                accept;
  logic                startRun;
  logic                compareEn;
  logic                isMatch;

  alu_ref_model #(.DATA_W(DATA_W)) uRefModel (
    .opcode (bus.iOPCODE),
    .a      (bus.iDATAIN1),
    .b      (bus.iDATAIN2),
    .result (expNow)
  );

  assign accept    = (state == ST_RUN) && bus.iVALID;
  assign startRun  = (state == ST_IDLE) && bus.iSTART;
  // The tail of the pipe only holds live samples outside IDLE.
  assign compareEn = (state != ST_IDLE) && pipeValid[LATENCY-1];
  assign isMatch   = (pipeExp[LATENCY-1] == bus.iDUTOUT);

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (bus.iSTART) stateNext = ST_RUN;
      ST_RUN:   if (bus.iSTOP) stateNext = ST_DRAIN;
      ST_DRAIN: if (drainCnt == '0) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      state    <= ST_IDLE;
      drainCnt <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      state <= stateNext;
      // Decoding stateNext keeps oBUSY/oDONE aligned with the registered state.
      busyQ <= (stateNext == ST_RUN) || (stateNext == ST_DRAIN);
      doneQ <= (stateNext == ST_DONE);
      if ((state == ST_RUN) && bus.iSTOP) begin
        drainCnt <= DRAIN_LOAD;
      end else if ((state == ST_DRAIN) && (drainCnt != '0)) begin
        drainCnt <= drainCnt - DRAIN_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeExp[i]   <= '0;
        pipeOp[i]    <= '0;
        pipeIdx[i]   <= '0;
      end
    end else begin
      pipeValid[0] <= accept;
      pipeExp[0]   <= expNow;
      pipeOp[0]    <= bus.iOPCODE;
      pipeIdx[0]   <= sampleIdx;
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeExp[i]   <= pipeExp[i-1];
        pipeOp[i]    <= pipeOp[i-1];
        pipeIdx[i]   <= pipeIdx[i-1];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      passCnt   <= '0;
      failCnt   <= '0;
      errQ      <= 1'b0;
      failIdx   <= '0;
      failOp    <= '0;
      failExp   <= '0;
      failGot   <= '0;
      sampleIdx <= '0;
    end else if (startRun) begin
      passCnt   <= '0;
      failCnt   <= '0;
      errQ      <= 1'b0;
      failIdx   <= '0;
      failOp    <= '0;
      failExp   <= '0;
      failGot   <= '0;
      sampleIdx <= '0;
    end else begin
      if (accept) begin
        sampleIdx <= sampleIdx + CNT_W'(1);
      end
      if (compareEn) begin
        if (isMatch) begin
          if (passCnt != '1) passCnt <= passCnt + CNT_W'(1);
        end else begin
          if (failCnt != '1) failCnt <= failCnt + CNT_W'(1);
          errQ <= 1'b1;
          // Only the first mismatch of a run is captured.
          if (!errQ) begin
            failIdx <= pipeIdx[LATENCY-1];
            failOp  <= pipeOp[LATENCY-1];
            failExp <= pipeExp[LATENCY-1];
            failGot <= bus.iDUTOUT;
          end
        end
      end
    end
  end

  assign bus.oBUSY        = busyQ;
  assign bus.oDONE        = doneQ;
  assign bus.oPASS_CNT    = passCnt;
  assign bus.oFAIL_CNT    = failCnt;
  assign bus.oERR         = errQ;
  assign bus.oFAIL_IDX    = failIdx;
  assign bus.oFAIL_OPCODE = failOp;
  assign bus.oFAIL_EXP    = failExp;
  assign bus.oFAIL_GOT    = failGot;

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Self-checking response side of the ALU interface.
- Sits beside `alu` and snoops the same operand/opcode bus that drives it.
- Computes the expected result with an internal reference model, delays it to match ALU latency, and compares it against the ALU output.
- Counts passes and fails, and captures the first mismatch for debug. It can be used in simulation or as on-chip BIST.

Parameters:
- DATA_W, 8: operand/result width.
- LATENCY, 1: ALU pipeline depth in clocks; legal range 1..8.
- CNT_W, 16: width of the pass, fail and index counters.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRSTN  in  1  reset, synchronous, active-low.
- iSTART  in  1  begin a check run; honoured only in IDLE.
- iSTOP  in  1  end of stimulus; honoured only in RUN.
- iVALID  in  1  operands and opcode on the bus are a sample this cycle.
- iOPCODE  in  2  ALU opcode.
- iDATAIN1  in  DATA_W  operand A.
- iDATAIN2  in  DATA_W  operand B.
- iDUTOUT  in  DATA_W  ALU oDATAOUT.
- oBUSY  out  1  high in RUN or DRAIN.
- oDONE  out  1  one-cycle pulse at end of run.
- oPASS_CNT  out  CNT_W  matching samples.
- oFAIL_CNT  out  CNT_W  mismatching samples.
- oERR  out  1  sticky; high after any mismatch in the current run.
- oFAIL_IDX  out  CNT_W  sample index of the first mismatch.
- oFAIL_OPCODE  out  2  opcode of the first mismatch.
- oFAIL_EXP  out  DATA_W  expected value at the first mismatch.
- oFAIL_GOT  out  DATA_W  observed value at the first mismatch.

Behaviour:
- Opcodes, with all results truncated mod 2^DATA_W:
  - 00 ADD: A+B
  - 01 SUB: A-B
  - 10 AND: A&B
  - 11 OR: A|B
- Reset (iRSTN=0 at an edge), including mid-run:
  - State goes to IDLE.
  - All outputs go to 0.
  - All pipeline valid bits are cleared, so no compares occur from pre-reset samples.
- FSM states:
  - IDLE: iSTART=1 -> RUN. On that edge, clear the counters, oERR, the failure-capture registers and the sample index.
  - RUN: each edge with iVALID=1 accepts a sample. iSTOP=1 -> DRAIN. A sample presented together with iSTOP is still accepted.
  - DRAIN: iVALID is ignored. Stay LATENCY cycles using a down-counter, then -> DONE.
  - DONE: oDONE=1 for exactly one cycle -> IDLE. Counters and capture registers hold their values until the next iSTART.
- iSTART outside IDLE is ignored. iSTOP outside RUN is ignored. If iSTART and iSTOP are both high in IDLE, START wins and STOP is dropped.
- Pipeline and compare:
  - An accepted sample pushes {valid, expected, opcode, index} into a LATENCY-deep shift register.
  - A sample accepted at edge k is compared with iDUTOUT sampled at edge k+LATENCY.
  - Compares happen in RUN, DRAIN and DONE whenever the last stage is valid.
- Compare result:
  - Match: oPASS_CNT increments.
  - Mismatch: oFAIL_CNT increments and oERR is set.
  - On the first mismatch of a run only, load oFAIL_IDX, oFAIL_OPCODE, oFAIL_EXP and oFAIL_GOT; they are frozen afterwards.
- Pass and fail counters saturate at all-ones and never wrap.
- The sample index increments per accepted sample and wraps modulo 2^CNT_W.
- oBUSY is a registered decode of the state.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR;
  - FSM state encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
- The same package is reused by `alu`.
- One sub-module, alu_ref_model: combinational, takes (opcode, A, B) and returns the expected DATA_W result. It is instanced once in the checker and is reusable by other benches.

Test Plan:
1. LATENCY=1, iSTART, then 4 samples: ADD F0+20, SUB 03-05, AND 3C&0F, OR 50|05. A correct ALU returns 10, FE, 0C, 55. Then iSTOP. Required: oPASS_CNT=4, oFAIL_CNT=0, oERR=0, and oDONE pulses 2 cycles after iSTOP (1 DRAIN cycle + DONE).
2. Fault injection: force iDUTOUT=00 on sample index 2 (AND 3C&0F). Required: oFAIL_CNT=1, oPASS_CNT=3, oERR=1, oFAIL_IDX=2, oFAIL_OPCODE=10, oFAIL_EXP=0C, oFAIL_GOT=00. A later forced mismatch on index 3 leaves the capture registers unchanged.
3. Saturation: CNT_W=2, 6 matching samples. Required: oPASS_CNT=3. The index wraps 0,1,2,3,0,1.
4. LATENCY=3 with a 3-stage ALU, iSTOP asserted in the same cycle as the last iVALID. Required: all samples compared, DRAIN lasts 3 cycles, oPASS_CNT equals the number of samples.
5. Reset mid-run: drop iRSTN for 1 cycle with 2 samples in flight. Required: all outputs 0 and state IDLE on the next cycle, no counter increments afterwards, and iSTOP ignored until a new iSTART.
6. iSTART and iSTOP both high in IDLE -> RUN entered, oBUSY=1. A further iSTART in RUN does not clear the counters.
